// File: rtl/aclk_time_counter.sv
// 24-hour HH:MM BCD time-of-day counter: advances on the one_minute strobe and
// accepts a one-cycle load of user-entered digits, optionally range-checked.
module aclk_time_counter #(
    parameter bit LOAD_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_ms_hr,
    input  logic [3:0] new_ls_hr,
    input  logic [3:0] new_ms_min,
    input  logic [3:0] new_ls_min,
    output logic [3:0] cur_ms_hr,
    output logic [3:0] cur_ls_hr,
    output logic [3:0] cur_ms_min,
    output logic [3:0] cur_ls_min,
    output logic       minute_tick,
    output logic       day_wrap,
    output logic       load_err
);

    logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
    logic       tick_q, wrap_q, err_q;
    logic       tick_d, wrap_d, err_d;

    logic       load_legal;
    logic       load_accept;
    logic [3:0] adv_ms_hr, adv_ls_hr, adv_ms_min, adv_ls_min;
    logic       adv_day_wrap;
    logic       carry_min, carry_hr;

    always_comb begin
        load_legal = (new_ms_hr <= 4'd2) && (new_ls_hr <= 4'd9) &&
                     !((new_ms_hr == 4'd2) && (new_ls_hr > 4'd3)) &&
                     (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9);
        load_accept = !LOAD_CHECK || load_legal;
    end

    // Any digit at or above its maximum wraps with carry, so an illegal value
    // left by an unchecked load recovers on the next advance instead of sticking.
    always_comb begin
        // NOTE: every output of this block is assigned a default first so no
        // path leaves a variable unassigned and no latch is inferred.
        adv_ms_hr    = ms_hr_q;
        adv_ls_hr    = ls_hr_q;
        adv_ms_min   = ms_min_q;
        adv_ls_min   = ls_min_q + 4'd1;
        adv_day_wrap = 1'b0;
        carry_min    = (ls_min_q >= 4'd9);
        carry_hr     = 1'b0;

        if (carry_min) begin
            adv_ls_min = 4'd0;
            if (ms_min_q >= 4'd5) begin
                adv_ms_min = 4'd0;
                carry_hr   = 1'b1;
            end else begin
                adv_ms_min = ms_min_q + 4'd1;
            end
        end

        if (carry_hr) begin
            if ((ms_hr_q > 4'd2) || ((ms_hr_q == 4'd2) && (ls_hr_q >= 4'd3))) begin
                adv_ms_hr    = 4'd0;
                adv_ls_hr    = 4'd0;
                adv_day_wrap = 1'b1;
            end else if (ls_hr_q >= 4'd9) begin
                adv_ls_hr = 4'd0;
                adv_ms_hr = ms_hr_q + 4'd1;
            end else begin
                adv_ls_hr = ls_hr_q + 4'd1;
            end
        end
    end

    // Load beats advance; a strobe coinciding with a load is dropped.
    always_comb begin
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;

        if (load_new_c) begin
            if (load_accept) begin
                ms_hr_d  = new_ms_hr;
                ls_hr_d  = new_ls_hr;
                ms_min_d = new_ms_min;
                ls_min_d = new_ls_min;
            end else begin
                err_d = 1'b1;
            end
        end else if (one_minute) begin
            ms_hr_d  = adv_ms_hr;
            ls_hr_d  = adv_ls_hr;
            ms_min_d = adv_ms_min;
            ls_min_d = adv_ls_min;
            tick_d   = 1'b1;
            wrap_d   = adv_day_wrap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= 4'd0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ms_hr_q  <= ms_hr_d;
            ls_hr_q  <= ls_hr_d;
            ms_min_q <= ms_min_d;
            ls_min_q <= ls_min_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign cur_ms_hr   = ms_hr_q;
    assign cur_ls_hr   = ls_hr_q;
    assign cur_ms_min  = ms_min_q;
    assign cur_ls_min  = ls_min_q;
    assign minute_tick = tick_q;
    assign day_wrap    = wrap_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: directed and random stimulus scored against a
// minutes-of-day reference model through an expectation queue.
module tb_aclk_time_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_minute;
    logic       load_new_c;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic [3:0] cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
    logic       minute_tick, day_wrap, load_err;

    aclk_time_counter #(.LOAD_CHECK(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .one_minute (one_minute),
        .load_new_c (load_new_c),
        .new_ms_hr  (new_ms_hr),
        .new_ls_hr  (new_ls_hr),
        .new_ms_min (new_ms_min),
        .new_ls_min (new_ls_min),
        .cur_ms_hr  (cur_ms_hr),
        .cur_ls_hr  (cur_ls_hr),
        .cur_ms_min (cur_ms_min),
        .cur_ls_min (cur_ls_min),
        .minute_tick(minute_tick),
        .day_wrap   (day_wrap),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;
    int model_min = 0;            // reference time as minutes since midnight
    logic [18:0] exp_q[$];        // {hh tens, hh units, mm tens, mm units, tick, wrap, err}

    function automatic logic [18:0] expect_word(input int m, input bit t, input bit w, input bit e);
        int hh, mm;
        hh = m / 60;
        mm = m % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), t, w, e};
    endfunction

    function automatic logic [18:0] actual_word();
        return {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, minute_tick, day_wrap, load_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                tick_cnt += int'(minute_tick);
                wrap_cnt += int'(day_wrap);
            end
            if (exp_q.size() > 0) check("scoreboard", 32'(actual_word()), 32'(exp_q.pop_front()));
        end
    end

    // Drive one cycle of inputs and push the response the model predicts.
    task automatic step(input bit ld, input bit om,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        bit t, w, e;
        int hh, mm;
        @(negedge clk);
        #1;
        load_new_c = ld;
        one_minute = om;
        new_ms_hr  = a;
        new_ls_hr  = b;
        new_ms_min = c;
        new_ls_min = d;
        t = 1'b0;
        w = 1'b0;
        e = 1'b0;
        if (ld) begin
            hh = int'(a) * 10 + int'(b);
            mm = int'(c) * 10 + int'(d);
            if (hh < 24 && b <= 4'd9 && c <= 4'd5 && d <= 4'd9) model_min = hh * 60 + mm;
            else e = 1'b1;
        end else if (om) begin
            w = (model_min == 1439);
            model_min = (model_min + 1) % 1440;
            t = 1'b1;
        end
        exp_q.push_back(expect_word(model_min, t, w, e));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic load_time(input int hh, input int mm);
        step(1'b1, 1'b0, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10));
    endtask

    // Asserts reset away from any clock edge and checks it acts at once.
    task automatic apply_reset(input string name);
        @(posedge clk);
        #1;
        exp_q.delete();
        reset      = 1'b0;
        load_new_c = 1'b0;
        one_minute = 1'b0;
        model_min  = 0;
        #1;
        check(name, 32'(actual_word()), 32'(expect_word(0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        one_minute = 1'b0;
        load_new_c = 1'b0;
        new_ms_hr  = 4'd0;
        new_ls_hr  = 4'd0;
        new_ms_min = 4'd0;
        new_ls_min = 4'd0;
        #1;
        check("reset_initial", 32'(actual_word()), 32'(expect_word(0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        #1;
        reset = 1'b1;
        idle(3);

        // Minute and hour carries
        load_time(12, 59);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);
        load_time(9, 59);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);

        // Day wrap and the step after it
        load_time(23, 59);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);

        // Rejected loads, including a load held over several cycles
        load_time(7, 15);
        step(1'b1, 1'b0, 4'd2, 4'd4, 4'd0, 4'd0);
        step(1'b1, 1'b0, 4'd1, 4'd9, 4'd6, 4'd0);
        step(1'b1, 1'b0, 4'd2, 4'd4, 4'd0, 4'hA);
        step(1'b1, 1'b0, 4'd1, 4'hA, 4'd0, 4'd0);
        step(1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'hC);
        idle(1);
        load_time(20, 30);
        idle(1);

        // Load and strobe together: the strobe is discarded
        load_time(10, 10);
        step(1'b1, 1'b1, 4'd0, 4'd5, 4'd0, 4'd5);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);

        // Random mix of loads (legal and arbitrary digits) and strobes
        for (int i = 0; i < 400; i++) begin
            bit ld, om;
            ld = ($urandom_range(0, 7) == 0);
            om = ($urandom_range(0, 1) == 1);
            if (ld && $urandom_range(0, 1) == 1) begin
                int hh, mm;
                hh = int'($urandom_range(0, 23));
                mm = int'($urandom_range(0, 59));
                step(1'b1, om, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10));
            end else begin
                step(ld, om, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
        end
        idle(1);

        // Accelerated free run over one full day
        apply_reset("reset_before_freerun");
        @(negedge clk);
        #1;
        tick_cnt = 0;
        wrap_cnt = 0;
        for (int i = 0; i < 1440; i++) step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(1);
        check("freerun_ticks", 32'(tick_cnt), 32'd1440);
        check("freerun_wraps", 32'(wrap_cnt), 32'd1);

        // Reset in the middle of a run
        for (int i = 0; i < 700; i++) step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        apply_reset("reset_mid_run");
        idle(3);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(2);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aclk_time_counter.md
# aclk_time_counter

Minute/hour BCD time-of-day counter for the alarm clock. Sits directly downstream of the time generator: it consumes the generator's `one_minute` strobe and advances a 24-hour HH:MM value held as four BCD digits. It also accepts a one-cycle load of a user-entered time. Its digit outputs feed the alarm comparator and the display driver.

## Interface
- `LOAD_CHECK`, default 1: 1 = validate loaded time and reject illegal values; 0 = load digits unchecked.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `one_minute`  in  1  one-cycle strobe from the time generator; one pulse = one minute elapsed.
- `load_new_c`  in  1  one-cycle request to load the `new_*` digits as the current time.
- `new_ms_hr`  in  4  BCD tens-of-hours to load (legal 0–2).
- `new_ls_hr`  in  4  BCD units-of-hours to load (legal 0–9; 0–3 when `new_ms_hr`=2).
- `new_ms_min`  in  4  BCD tens-of-minutes to load (legal 0–5).
- `new_ls_min`  in  4  BCD units-of-minutes to load (legal 0–9).
- `cur_ms_hr`, `cur_ls_hr`, `cur_ms_min`, `cur_ls_min`  out  4 each  current time, registered BCD.
- `minute_tick`  out  1  one-cycle pulse, registered; set in the cycle the time advanced due to `one_minute`.
- `day_wrap`  out  1  one-cycle pulse, registered; set when 23:59 rolled to 00:00.
- `load_err`  out  1  one-cycle pulse, registered; set when a load was rejected.

## Operation
- Reset (`reset`=0, asynchronous) forces:
  - all `cur_*` = 0, i.e. 00:00;
  - `minute_tick`, `day_wrap`, `load_err` = 0.
- Reset takes effect immediately, including mid-load or mid-carry. Release is synchronous in effect: the first edge with `reset`=1 evaluates inputs normally.
- Priority per rising edge: `load_new_c` > `one_minute` > hold.
- Load, when `load_new_c`=1:
  - If `LOAD_CHECK`=0, or all digits are legal, the `cur_*` registers take the `new_*` digits.
  - Otherwise (`LOAD_CHECK`=1 and any digit illegal) the time is unchanged and `load_err` pulses.
  - A `one_minute` arriving in the same cycle is discarded; it is not deferred. `minute_tick` and `day_wrap` stay 0.
- Advance, when `one_minute`=1 and no load:
  - `ls_min` increments.
  - 9→0 carries into `ms_min`.
  - `ms_min` 5→0 carries into the hour digits.
  - Hour counts 00..23: `ls_hr` 9→0 with `ms_hr`+1. At 23 (`ms_hr`=2, `ls_hr`=3) a carry gives `ms_hr`=0, `ls_hr`=0.
  - `minute_tick`=1 for that cycle; `day_wrap`=1 only on the 23:59→00:00 step.
- All carries resolve in the same edge; there are no intermediate visible states.
- Defensive recovery: if `cur_*` ever holds an illegal value (only possible with `LOAD_CHECK`=0), the next advance treats any digit above its maximum as being at its wrap point and wraps it to 0 with carry. Example: `ls_min`=0xC advances to 0 with carry. The counter must never lock up.
- Pulse outputs are 0 in every cycle not described above.

## Timing
- Latency: the `one_minute` or `load_new_c` edge sampled at edge N gives updated `cur_*` and pulses visible after edge N; they are valid throughout cycle N+1.
- Pulses last exactly one clock.
- Back-to-back `one_minute` strobes (every cycle) advance one minute per cycle; this is required for accelerated test.
- `load_new_c` held high for multiple cycles reloads every cycle. `load_err` repeats each cycle while the digits remain illegal.
- The block is fully synchronous to `clk`; inputs are assumed synchronous from upstream stages.

## Test plan
- Reset then idle: pulse `reset` low at any time → `cur_*`=0,0,0,0 and all pulses 0 immediately. The time stays 00:00 with no `one_minute`.
- Minute/hour carry: load 12:59, then one `one_minute` → 13:00, `minute_tick`=1 for one cycle, `day_wrap`=0. Also load 09:59 + tick → 10:00.
- Day wrap: load 23:59, one tick → 00:00 with `minute_tick`=1 and `day_wrap`=1 on the same cycle. A further tick → 00:01 with `day_wrap`=0.
- Illegal load (`LOAD_CHECK`=1): from 07:15, load 24:00, then 19:60, then 2:4x → time stays 07:15 and `load_err` pulses each attempt. A legal load of 20:30 → 20:30 with no `load_err`.
- Simultaneous events: from 10:10, assert `load_new_c`(05:05) and `one_minute` together → 05:05 with `minute_tick`=0. The next tick → 05:06.
- Free run with the generator's strobe every cycle for 1440 cycles from 00:00 → returns to 00:00. Exactly one `day_wrap`, 1440 `minute_tick`s. Assert `reset` low mid-run → immediate 00:00.
